pulse_stretcher_mc: RTL and testbench
=====================================

# pulse_stretcher_mc

Multi-channel, parametrised pulse stretcher. Each of CH independent channels turns a trigger on its input into an output pulse of runtime-programmable length. Each channel has a selectable retrigger or non-retrigger mode, an optional post-pulse holdoff, and drop reporting. It sits between event sources (fault flags, strobes, interrupt pulses) and slow consumers or LEDs that need a guaranteed minimum pulse width.

## Interface
- CH, default 4: number of independent channels (1..32).
- CW, default 8: width of each channel's length field and counter.
- HOLD, default 0: holdoff cycles after each output pulse; 0 disables holdoff.
- EDGE, default 0: 0 = every cycle in_pulse[i] is high is a trigger; 1 = only a rising edge of in_pulse[i] is a trigger.
- clk  input  1  clock; all logic is on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_pulse  input  CH  trigger inputs; synchronous to clk.
- len  input  CH*CW  per-channel stretch length; channel i uses len[i*CW +: CW]; value 0 is treated as 1.
- retrig  input  CH  per-channel mode: 1 = retrigger, 0 = non-retrigger.
- clr  input  CH  per-channel synchronous abort.
- out_pulse  output  CH  registered stretched outputs.
- busy  output  CH  registered; high while the channel is in STRETCH or HOLDOFF.
- drop  output  CH  registered; one-cycle pulse for each rejected trigger.
- any_active  output  1  OR of out_pulse; no additional register stage.

## Operation
- Per-channel state machine, states IDLE, STRETCH, HOLDOFF; counter cnt[CW-1:0]; holdoff counter hcnt of width $clog2(HOLD+1), minimum 1 bit.
- Trigger detection:
  - EDGE=0: trig = in_pulse[i].
  - EDGE=1: trig = in_pulse[i] & ~prev[i]. prev resets to 1, so an input that is already high at reset release does not trigger.
- Length capture: len is sampled only when a trigger is accepted. Changing len mid-pulse has no effect on the pulse in progress.
- Priority on each cycle: clr > trigger > count.
- clr[i]: next state IDLE, out_pulse low, cnt and hcnt cleared, no drop pulse; a trigger in the same cycle is ignored. prev is still updated.
- IDLE + trig: go to STRETCH, out_pulse <= 1, cnt <= max(len,1) - 1.
- STRETCH, no trig:
  - cnt != 0: cnt decrements, out_pulse stays 1.
  - cnt == 0: out_pulse <= 0; go to HOLDOFF with hcnt <= HOLD-1 if HOLD > 0, otherwise go to IDLE.
- STRETCH + trig:
  - retrig=1: cnt reloads to max(len,1) - 1 and out_pulse stays 1. This includes the cnt==0 cycle, so the output is continuous.
  - retrig=0: trigger rejected, drop[i] <= 1, counting continues unchanged.
- HOLDOFF:
  - out_pulse is 0; any trigger is rejected with drop[i] <= 1.
  - hcnt == 0 → IDLE; otherwise hcnt decrements.
- busy[i] is high exactly when the state is not IDLE.
- Channels are fully independent; no shared arbitration.

## Timing
- Reset values: out_pulse=0, busy=0, drop=0, any_active=0, all states IDLE, cnt=0, hcnt=0, prev all 1.
- Latency: a trigger sampled at edge t gives out_pulse high after edge t. It stays high for exactly max(len,1) cycles and falls after edge t+max(len,1), unless retriggered.
- Minimum trigger spacing for a second accepted pulse in non-retrigger mode is max(len,1)+1+HOLD edges. That spacing always guarantees at least one low cycle (HOLD+1 low cycles when HOLD > 0).
- drop is asserted the cycle after the rejected trigger and lasts one cycle per rejected trigger. With EDGE=0, a held-high input during STRETCH in non-retrigger mode gives drop high continuously.
- Reset asserted mid-pulse clears all outputs immediately (asynchronous). After release, the first edge behaves as from IDLE.
- len=0 gives a 1-cycle pulse, identical to len=1.
- len=2^CW-1 gives a pulse of 2^CW-1 cycles; the counter never wraps.

## Test plan
- CH=4, EDGE=0, HOLD=0, ch0 len=5, retrig=0: one-cycle trigger at edge 10 → out_pulse[0] high after edges 10..14, low after edge 15; busy[0] matches; other channels stay 0.
- ch1 len=4, retrig=1: triggers at edges 10 and 12 → out_pulse[1] high continuously from after edge 10 to after edge 15, low after edge 16, no drop.
- ch2 len=4, retrig=0, HOLD=2: triggers at 10, 12, 14, 16, 17 → pulse after edges 10..13; drop after edges 12, 14, 16; trigger at 17 accepted (IDLE reached after edge 16).
- EDGE=1: in_pulse[3] held high from before reset release → no pulse. Low then high at edge 20 with len=3 → single 3-cycle pulse; holding high adds no triggers.
- clr[0] at edge 12 during a len=8 pulse started at 10, with trigger also at 12 → out_pulse[0] low after edge 12, state IDLE, no drop; trigger at 13 accepted.
- Async reset mid-pulse on all channels; len=0 single trigger → all outputs 0 during reset; len=0 gives exactly one high cycle, and any_active tracks the OR throughout.

Source files
------------

// File: rtl/pulse_stretcher_mc.sv
`default_nettype none
// =============================================================================
// Module      : pulse_stretcher_mc
// Description : CH independent pulse stretchers with programmable length,
//               retrigger/non-retrigger mode, optional holdoff, drop reporting.
// Revision    : 1.0 - initial release
// =============================================================================
module pulse_stretcher_mc #(
    parameter int CH   = 4,
    parameter int CW   = 8,
    parameter int HOLD = 0,
    parameter int EDGE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CH-1:0]    in_pulse,
    input  logic [CH*CW-1:0] len,
    input  logic [CH-1:0]    retrig,
    input  logic [CH-1:0]    clr,
    output logic [CH-1:0]    out_pulse,
    output logic [CH-1:0]    busy,
    output logic [CH-1:0]    drop,
    output logic             any_active
);

    localparam int              HW      = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
    localparam int              HOLD_M1 = (HOLD > 0) ? HOLD - 1 : 0;
    localparam logic [HW-1:0]   HLOAD   = HW'(HOLD_M1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STRETCH = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    logic [CH-1:0] trig;

    // prev resets high so an input already asserted at reset release is not an edge
    generate
        if (EDGE != 0) begin : g_edge
            logic [CH-1:0] prev;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) prev <= '1;
                else        prev <= in_pulse;
            end
            assign trig = in_pulse & ~prev;
        end else begin : g_level
            assign trig = in_pulse;
        end
    endgenerate

    for (genvar i = 0; i < CH; i++) begin : g_ch
        state_t         state, state_nxt;
        logic [CW-1:0]  cnt, cnt_nxt, len_raw, cnt_load;
        logic [HW-1:0]  hcnt, hcnt_nxt;
        logic           out_q, busy_q, drop_q;
        logic           out_nxt, busy_nxt, drop_nxt;

        assign len_raw  = len[i*CW +: CW];
        assign cnt_load = (len_raw == '0) ? '0 : len_raw - CW'(1);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state  <= IDLE;
                cnt    <= '0;
                hcnt   <= '0;
                out_q  <= 1'b0;
                busy_q <= 1'b0;
                drop_q <= 1'b0;
            end else begin
                state  <= state_nxt;
                cnt    <= cnt_nxt;
                hcnt   <= hcnt_nxt;
                out_q  <= out_nxt;
                busy_q <= busy_nxt;
                drop_q <= drop_nxt;
            end
        end

        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            hcnt_nxt  = hcnt;
            drop_nxt  = 1'b0;
            if (clr[i]) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                hcnt_nxt  = '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (trig[i]) begin
                            state_nxt = STRETCH;
                            cnt_nxt   = cnt_load;
                        end
                    end
                    STRETCH: begin
                        // a retrigger on the final count keeps the output continuous
                        if (trig[i] && retrig[i]) begin
                            cnt_nxt = cnt_load;
                        end else begin
                            drop_nxt = trig[i];
                            if (cnt != '0) begin
                                cnt_nxt = cnt - CW'(1);
                            end else if (HOLD > 0) begin
                                state_nxt = HOLDOFF;
                                hcnt_nxt  = HLOAD;
                            end else begin
                                state_nxt = IDLE;
                            end
                        end
                    end
                    HOLDOFF: begin
                        drop_nxt = trig[i];
                        if (hcnt == '0) state_nxt = IDLE;
                        else            hcnt_nxt  = hcnt - HW'(1);
                    end
                    default: begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        hcnt_nxt  = '0;
                    end
                endcase
            end
            out_nxt  = (state_nxt == STRETCH);
            busy_nxt = (state_nxt != IDLE);
        end

        assign out_pulse[i] = out_q;
        assign busy[i]      = busy_q;
        assign drop[i]      = drop_q;
    end

    assign any_active = |out_pulse;

endmodule
`default_nettype wire

// File: tb/tb_pulse_stretcher_mc.sv
`default_nettype none
// Bench for pulse_stretcher_mc: three parameter variants driven in parallel and
// compared each cycle against a remaining-cycles model of every channel.
module tb_pulse_stretcher_mc;

    localparam int CH = 4;
    localparam int CW = 8;
    localparam int ND = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [CH-1:0]    in_pulse, retrig, clr;
    logic [CH*CW-1:0] len;
    logic [CH-1:0]    outp  [ND];
    logic [CH-1:0]    busyv [ND];
    logic [CH-1:0]    dropv [ND];
    logic             anyv  [ND];

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    // model: rem = high cycles still to come, hold = holdoff cycles still to come
    int rem   [ND][CH];
    int hold  [ND][CH];
    bit mdrop [ND][CH];
    bit prev  [ND][CH];

    always #5 clk = ~clk;

    pulse_stretcher_mc #(.CH(CH), .CW(CW), .HOLD(0), .EDGE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_pulse(in_pulse), .len(len), .retrig(retrig), .clr(clr),
        .out_pulse(outp[0]), .busy(busyv[0]), .drop(dropv[0]), .any_active(anyv[0]));
    pulse_stretcher_mc #(.CH(CH), .CW(CW), .HOLD(2), .EDGE(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_pulse(in_pulse), .len(len), .retrig(retrig), .clr(clr),
        .out_pulse(outp[1]), .busy(busyv[1]), .drop(dropv[1]), .any_active(anyv[1]));
    pulse_stretcher_mc #(.CH(CH), .CW(CW), .HOLD(1), .EDGE(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_pulse(in_pulse), .len(len), .retrig(retrig), .clr(clr),
        .out_pulse(outp[2]), .busy(busyv[2]), .drop(dropv[2]), .any_active(anyv[2]));

    function automatic int hold_of(int d);
        return (d == 1) ? 2 : (d == 2) ? 1 : 0;
    endfunction

    function automatic bit edge_of(int d);
        return d == 2;
    endfunction

    function automatic logic [3*CH:0] dut_vec(int d);
        return {outp[d], busyv[d], dropv[d], anyv[d]};
    endfunction

    function automatic logic [3*CH:0] exp_vec(int d);
        logic [CH-1:0] o, b, r;
        for (int c = 0; c < CH; c++) begin
            o[c] = rem[d][c] > 0;
            b[c] = (rem[d][c] > 0) || (hold[d][c] > 0);
            r[c] = mdrop[d][c];
        end
        return {o, b, r, |o};
    endfunction

    task automatic model_reset();
        for (int d = 0; d < ND; d++)
            for (int c = 0; c < CH; c++) begin
                rem[d][c] = 0; hold[d][c] = 0; mdrop[d][c] = 0; prev[d][c] = 1;
            end
    endtask

    task automatic model_edge(int d, int c);
        int L;
        bit t;
        L = int'(len[c*CW +: CW]);
        if (L == 0) L = 1;
        t = in_pulse[c] && (!edge_of(d) || !prev[d][c]);
        prev[d][c]  = in_pulse[c];
        mdrop[d][c] = 0;
        if (clr[c]) begin
            rem[d][c] = 0; hold[d][c] = 0;
        end else if (rem[d][c] > 0) begin
            if (t && retrig[c]) rem[d][c] = L;
            else begin
                mdrop[d][c] = t;
                rem[d][c]--;
                if (rem[d][c] == 0) hold[d][c] = hold_of(d);
            end
        end else if (hold[d][c] > 0) begin
            mdrop[d][c] = t;
            hold[d][c]--;
        end else if (t) begin
            rem[d][c] = L;
        end
    endtask

    // one clock: inputs already set at the falling edge, model follows the rising edge
    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else
            for (int d = 0; d < ND; d++)
                for (int c = 0; c < CH; c++) model_edge(d, c);
        cyc++;
        @(negedge clk);
    endtask

    task automatic set_len(int c, logic [CW-1:0] v);
        len[c*CW +: CW] = v;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_pulse = 4'b1000; retrig = '0; clr = '0; len = '0;
        model_reset();
        tick(); tick();
        for (int d = 0; d < ND; d++) begin
            tests++;
            if (dut_vec(d) !== '0) begin
                failed++;
                $display("FAIL reset dut%0d got %h expected 0", d, dut_vec(d));
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_edge();
        int hi_c;
        hi_c = 0;
        set_len(3, 8'd3);
        for (int k = 0; k < 14; k++) begin
            if (k == 5) in_pulse[3] = 1'b0;
            if (k == 6) in_pulse[3] = 1'b1;
            tick();
            if (outp[2][3]) hi_c++;
            for (int d = 0; d < ND; d++) begin
                tests++;
                if (dut_vec(d) !== exp_vec(d)) begin
                    failed++;
                    $display("FAIL edge dut%0d cyc %0d got %h expected %h", d, cyc, dut_vec(d), exp_vec(d));
                end
            end
        end
        tests++;
        if (hi_c !== 3) begin
            failed++;
            $display("FAIL edge_width high cycles got %0d expected 3", hi_c);
        end
        in_pulse = '0;
    endtask

    task automatic run_seq(string name, int n, int ch, logic [31:0] trig_mask,
                           int clr_at, int dd, output int hi, output int dr);
        hi = 0; dr = 0;
        for (int k = 0; k < n; k++) begin
            in_pulse[ch] = trig_mask[k];
            clr[ch]      = (k == clr_at);
            tick();
            if (outp[dd][ch])  hi++;
            if (dropv[dd][ch]) dr++;
            for (int d = 0; d < ND; d++) begin
                tests++;
                if (dut_vec(d) !== exp_vec(d)) begin
                    failed++;
                    $display("FAIL %s dut%0d cyc %0d got %h expected %h", name, d, cyc, dut_vec(d), exp_vec(d));
                end
            end
        end
        in_pulse = '0; clr = '0;
    endtask

    task automatic test_single();
        int hi, dr;
        set_len(0, 8'd5); retrig[0] = 1'b0;
        run_seq("single", 12, 0, 32'h1, -1, 0, hi, dr);
        tests++;
        if (hi !== 5 || dr !== 0) begin
            failed++;
            $display("FAIL single_width got hi=%0d drop=%0d expected hi=5 drop=0", hi, dr);
        end
    endtask

    task automatic test_retrig();
        int hi, dr;
        set_len(1, 8'd4); retrig[1] = 1'b1;
        run_seq("retrig", 12, 1, 32'h5, -1, 0, hi, dr);
        tests++;
        if (hi !== 6 || dr !== 0) begin
            failed++;
            $display("FAIL retrig_width got hi=%0d drop=%0d expected hi=6 drop=0", hi, dr);
        end
    endtask

    task automatic test_holdoff();
        int hi, dr;
        set_len(2, 8'd4); retrig[2] = 1'b0;
        run_seq("holdoff", 18, 2, 32'hD5, -1, 1, hi, dr);
        tests++;
        if (hi !== 8 || dr !== 3) begin
            failed++;
            $display("FAIL holdoff_counts got hi=%0d drop=%0d expected hi=8 drop=3", hi, dr);
        end
    endtask

    task automatic test_clr();
        int hi, dr;
        set_len(0, 8'd8); retrig[0] = 1'b0;
        run_seq("clr", 14, 0, 32'hD, 2, 0, hi, dr);
        tests++;
        if (hi !== 10 || dr !== 0) begin
            failed++;
            $display("FAIL clr_counts got hi=%0d drop=%0d expected hi=10 drop=0", hi, dr);
        end
    endtask

    task automatic test_async_reset();
        int hi [ND][CH];
        for (int c = 0; c < CH; c++) set_len(c, 8'd6);
        retrig = '0; in_pulse = '1;
        tick();
        in_pulse = '0;
        tick();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        for (int d = 0; d < ND; d++) begin
            tests++;
            if (dut_vec(d) !== '0) begin
                failed++;
                $display("FAIL async_reset dut%0d got %h expected 0", d, dut_vec(d));
            end
        end
        tick();
        rst_n = 1'b1; len = '0; in_pulse = '1;
        for (int d = 0; d < ND; d++) for (int c = 0; c < CH; c++) hi[d][c] = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            in_pulse = '0;
            for (int d = 0; d < ND; d++) begin
                for (int c = 0; c < CH; c++) if (outp[d][c]) hi[d][c]++;
                tests++;
                if (dut_vec(d) !== exp_vec(d)) begin
                    failed++;
                    $display("FAIL len0 dut%0d cyc %0d got %h expected %h", d, cyc, dut_vec(d), exp_vec(d));
                end
            end
        end
        for (int c = 0; c < CH; c++) begin
            tests++;
            if (hi[0][c] !== 1 || hi[1][c] !== 1 || hi[2][c] !== 0) begin
                failed++;
                $display("FAIL len0_width ch%0d got %0d/%0d/%0d expected 1/1/0", c, hi[0][c], hi[1][c], hi[2][c]);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            if (k % 16 == 0)
                for (int c = 0; c < CH; c++) begin
                    set_len(c, ($urandom_range(0, 15) == 0) ? 8'd255 : 8'($urandom_range(0, 7)));
                    retrig[c] = $urandom_range(0, 1) == 1;
                end
            for (int c = 0; c < CH; c++) begin
                in_pulse[c] = $urandom_range(0, 3) == 0;
                clr[c]      = $urandom_range(0, 31) == 0;
            end
            tick();
            for (int d = 0; d < ND; d++) begin
                tests++;
                if (dut_vec(d) !== exp_vec(d)) begin
                    failed++;
                    $display("FAIL random dut%0d cyc %0d got %h expected %h", d, cyc, dut_vec(d), exp_vec(d));
                end
            end
        end
        in_pulse = '0; clr = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_edge();
        test_single();
        test_retrig();
        test_holdoff();
        test_clr();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
